// File: rtl/uart_arb_pkg.sv
// Shared definitions for the arbitrated UART transmitter.
//   tx_state_e        : serializer FSM states (IDLE, START, DATA, STOP)
//   DEFAULT_DIV_WIDTH : default width of the baud divisor
package uart_arb_pkg;

  localparam int DEFAULT_DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector. Purely combinational.
// Searches the request vector starting one position after last_grant and
// wrapping, so the most recently served requester has lowest priority.
//   req        : request vector, one bit per requester
//   last_grant : index of the requester served most recently
//   grant      : one-hot winner (all zero when no request)
//   grant_idx  : index of the winner (zero when no request)
//   grant_any  : high when some requester won
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Walk the candidates in priority order; the first asserted one wins and
  // every later candidate is masked off by grant_any.
  always_comb begin
    int   cand;
    logic take;
    cand      = 0;
    take      = 1'b0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand        = (int'(last_grant) + i) % NUM_REQ;
      take        = ~grant_any & req[cand];
      grant[cand] = take;
      grant_idx   = take ? IDX_W'(cand) : grant_idx;
      grant_any   = grant_any | take;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Multi-requester 8N1 UART transmitter with round-robin arbitration.
// One byte is accepted from the round-robin winner while the line is idle,
// then sent as START, 8 data bits LSB-first, STOP, each lasting div+1 clocks.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset, aborts any frame in flight
//   div_i       : bit period minus one, sampled when a byte is accepted
//   req_valid_i : per-requester byte valid
//   req_data_i  : packed bytes, requester k in bits [8k+7:8k]
//   req_ready_o : combinational accept, only the winner, only in IDLE
//   tx_o        : registered serial line, idle high
//   busy_o      : registered, high while a frame is on the line
//   grant_id_o  : index of the last accepted requester
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DIV_WIDTH-1:0]   div_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       grant_id_o
);

  tx_state_e            state, state_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_nxt;
  logic [7:0]           data_q, data_nxt;
  logic [DIV_WIDTH-1:0] div_q, div_nxt;
  logic [IDX_W-1:0]     last_grant, last_nxt;
  logic [IDX_W-1:0]     grant_id, gid_nxt;
  logic                 tx_q, tx_nxt;
  logic                 busy_q, busy_nxt;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [7:0]           sel_byte;
  logic                 in_idle;
  logic                 accept;
  logic                 bit_end;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

  assign in_idle = (state == ST_IDLE);
  // The arbiter only offers a grant to a requester that is valid, so any
  // grant while idle is also a completed handshake.
  assign accept  = in_idle & arb_any;
  // The counter wraps at the latched divisor, never at its own width, so an
  // all-ones divisor cannot overflow.
  assign bit_end = (cnt == div_q);

  assign req_ready_o = (in_idle && !rst_i) ? arb_grant : {NUM_REQ{1'b0}};
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_id;

  // Mux the winner's byte out of the packed data bus.
  always_comb begin
    sel_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_byte = sel_byte | (req_data_i[k*8 +: 8] & {8{arb_grant[k]}});
    end
  end

  // Next-state logic for the serializer FSM and its counters.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    data_nxt  = data_q;
    div_nxt   = div_q;
    last_nxt  = last_grant;
    gid_nxt   = grant_id;
    case (state)
      ST_IDLE: begin
        cnt_nxt = {DIV_WIDTH{1'b0}};
        bit_nxt = 3'd0;
        if (accept) begin
          state_nxt = ST_START;
          data_nxt  = sel_byte;
          div_nxt   = div_i;
          last_nxt  = arb_idx;
          gid_nxt   = arb_idx;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          cnt_nxt   = {DIV_WIDTH{1'b0}};
          bit_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_nxt = {DIV_WIDTH{1'b0}};
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
            bit_nxt   = 3'd0;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = {DIV_WIDTH{1'b0}};
        end else begin
          cnt_nxt = cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = {DIV_WIDTH{1'b0}};
        bit_nxt   = 3'd0;
      end
    endcase
  end

  // Line level and busy are computed from the next state so that the
  // registered copies line up exactly with the state register.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = data_nxt[bit_nxt];
      ST_STOP:  tx_nxt = 1'b1;
      ST_IDLE:  tx_nxt = 1'b1;
      default:  tx_nxt = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset drops any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cnt        <= {DIV_WIDTH{1'b0}};
      bit_idx    <= 3'd0;
      data_q     <= 8'h00;
      div_q      <= {DIV_WIDTH{1'b0}};
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_id   <= {IDX_W{1'b0}};
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_nxt;
      data_q     <= data_nxt;
      div_q      <= div_nxt;
      last_grant <= last_nxt;
      grant_id   <= gid_nxt;
      tx_q       <= tx_nxt;
      busy_q     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb.
// A reference model tracks frames as "remaining cycles" plus the 10-bit frame
// image and predicts tx/busy/ready/grant_id every cycle; each accepted byte is
// pushed to a scoreboard queue that an independent line monitor pops when it
// sees a frame start, decoding the serial bits at bit centres.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   div;
  logic [N-1:0]    valid;
  logic [N*8-1:0]  data;
  logic [N-1:0]    ready;
  logic            tx;
  logic            busy;
  logic [GW-1:0]   gid;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(N), .DIV_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .div_i       (div),
    .req_valid_i (valid),
    .req_data_i  (data),
    .req_ready_o (ready),
    .tx_o        (tx),
    .busy_o      (busy),
    .grant_id_o  (gid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [7:0] b; int d; } exp_t;
  exp_t sb_q[$];

  logic [N-1:0] hs_seen = '0;

  // model state
  bit         m_live = 1'b0;
  int         m_rem = 0, m_el = 0, m_div = 0, m_last = N-1, m_gid = 0;
  logic [7:0] m_byte = 8'h00;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: check this cycle's outputs, then advance across the edge.
  initial begin
    forever begin
      logic [9:0]   fr;
      logic [N-1:0] er;
      int           p;
      @(negedge clk);
      hs_seen = valid & ready;
      if (m_live) begin
        fr = {1'b1, m_byte, 1'b0};
        er = '0;
        p  = rr_pick(valid, m_last);
        if (m_rem == 0 && !rst && p >= 0) er[p] = 1'b1;
        chk("tx",    tx,    (m_rem > 0) ? fr[m_el / (m_div + 1)] : 1'b1);
        chk("busy",  busy,  m_rem > 0);
        chk("ready", ready, er);
        chk("grant_id", gid, m_gid);
      end
      if (rst) begin
        m_live = 1'b1; m_rem = 0; m_el = 0; m_last = N-1; m_gid = 0;
      end else if (m_live) begin
        if (m_rem > 0) begin
          m_rem--; m_el++;
        end else begin
          p = rr_pick(valid, m_last);
          if (p >= 0) begin
            m_byte = data[p*8 +: 8];
            m_div  = int'(div);
            m_rem  = 10 * (m_div + 1);
            m_el   = 0;
            m_last = p;
            m_gid  = p;
            sb_q.push_back('{m_byte, m_div});
          end
        end
      end
    end
  end

  // Line monitor: on each frame start pop the expected byte and decode.
  initial begin
    logic busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_live && busy && !busy_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          exp_t       e;
          logic [9:0] got;
          bit         aborted;
          int         len;
          e = sb_q.pop_front();
          len = 10 * (e.d + 1);
          got = '0;
          aborted = 1'b0;
          for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (!busy) begin
              aborted = 1'b1;
              break;
            end
            if (c % (e.d + 1) == e.d / 2) got[c / (e.d + 1)] = tx;
          end
          if (!aborted) begin
            chk("mon_start", got[0], 1'b0);
            chk("mon_byte",  got[8:1], e.b);
            chk("mon_stop",  got[9], 1'b1);
            @(negedge clk);
            chk("mon_frame_len", busy, 1'b0);
          end
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hs(int k);
    int t = 0;
    do begin
      tick(1);
      t++;
    end while (!hs_seen[k] && t < 5000);
    if (!hs_seen[k]) chk("handshake_timeout", 32'(k), 32'hFFFF_FFFF);
  endtask

  task automatic send(int k, logic [7:0] b);
    data[k*8 +: 8] = b;
    valid[k] = 1'b1;
    wait_hs(k);
    valid[k] = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    int t;
    rst = 1'b1; valid = '0; data = '0; div = 8'd3;
    tick(3);
    rst = 1'b0;
    tick(2);

    // single 0x55 frame at div 3
    div = 8'd3;
    send(0, 8'h55);
    tick(45);

    // one-cycle bits
    div = 8'd0;
    send(0, 8'hFF);
    tick(15);

    // all-ones divisor
    div = '1;
    send(1, 8'hC3);
    tick(2570);

    // all requesters continuously valid: A0,A1,A2,A3,A0, 41 cycles apart
    rst_pulse();
    div = 8'd3;
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      t = 0;
      do begin
        tick(1);
        t++;
      end while (hs_seen == '0 && t < 200);
      chk("rr_order", onehot_idx(hs_seen), i % N);
      if (i > 0) chk("rr_spacing", t, 41);
    end
    valid = '0;
    tick(45);

    // divisor change mid-frame only affects the next frame
    div = 8'd3;
    send(2, 8'h96);
    tick(10);
    div = 8'd7;
    send(3, 8'h3C);
    tick(85);

    // reset during data bit 3, then requester 0 beats requester 3
    div = 8'd3;
    send(2, 8'hA5);
    tick(17);
    rst = 1'b1;
    tick(1);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b0;
    data[7:0] = 8'h11;
    data[31:24] = 8'h33;
    valid = 4'b1001;
    wait_hs(0);
    chk("post_reset_prio", hs_seen, 4'b0001);
    valid[0] = 1'b0;
    wait_hs(3);
    valid[3] = 1'b0;
    tick(45);

    // requester 2 withdraws while requester 1 transmits
    rst_pulse();
    data[15:8] = 8'h5A;
    data[23:16] = 8'hE7;
    valid = 4'b0110;
    wait_hs(1);
    chk("withdraw_first", hs_seen, 4'b0010);
    valid[1] = 1'b0;
    tick(5);
    valid[2] = 1'b0;
    tick(50);
    chk("withdraw_idle_tx", tx, 1'b1);
    chk("withdraw_idle_busy", busy, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      for (int k = 0; k < N; k++) begin
        if (valid[k] && hs_seen[k]) begin
          if ($urandom_range(0, 1) == 0) data[k*8 +: 8] = 8'($urandom);
          else valid[k] = 1'b0;
        end else if (valid[k]) begin
          if ($urandom_range(0, 39) == 0) valid[k] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          data[k*8 +: 8] = 8'($urandom);
          valid[k] = 1'b1;
        end
      end
      if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 4));
      rst = ($urandom_range(0, 399) == 0);
    end
    valid = '0;
    rst = 1'b0;
    tick(100);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of the baud divisor.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port div_i  input  DIV_WIDTH  bit period minus one, in clk_i cycles.
REQ-007 SHALL have port req_valid_i  input  NUM_REQ  per-requester byte valid.
REQ-008 SHALL have port req_data_i  input  NUM_REQ*8  packed bytes; requester k in bits [8k+7:8k].
REQ-009 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-010 SHALL have port tx_o  output  1  serial line, 8N1, idle high.
REQ-011 SHALL have port busy_o  output  1  high while a frame is on the line (START..STOP).
REQ-012 SHALL have port grant_id_o  output  $clog2(NUM_REQ)  index of the last accepted requester.

Function
REQ-013 SHALL implement an FSM with states IDLE, START, DATA, STOP.
REQ-014 In IDLE, SHALL select a winner by round-robin among asserted req_valid_i, starting at (last_grant+1) mod NUM_REQ.
REQ-015 req_ready_o SHALL be combinational: only the winner's bit is high, only in IDLE; all bits are low elsewhere.
REQ-016 On valid&ready for requester k, SHALL latch the byte, latch div_i, set last_grant=k and grant_id_o=k, and enter START on the next cycle.
REQ-017 div_i changes during a frame SHALL NOT affect that frame.
REQ-018 START SHALL drive tx_o=0 for div+1 cycles.
REQ-019 DATA SHALL drive 8 bits LSB-first, each for div+1 cycles, using a 3-bit bit counter.
REQ-020 STOP SHALL drive tx_o=1 for div+1 cycles, then return to IDLE.
REQ-021 Frame length SHALL be exactly 10*(div+1) cycles.
REQ-022 IDLE SHALL last at least one cycle, so back-to-back frame starts are spaced 10*(div+1)+1 cycles.
REQ-023 The bit-period counter SHALL count 0..div and wrap at div; div=0 gives one-cycle bits.
REQ-024 The maximum divisor (all ones) SHALL work without overflow; the counter is DIV_WIDTH bits wide.
REQ-025 A requester dropping valid before being granted SHALL NOT be granted; no byte is latched for it.
REQ-026 When only one requester is valid, it SHALL be granted regardless of last_grant.
REQ-027 tx_o and busy_o SHALL be registered outputs.

Reset
REQ-028 Reset SHALL set: state=IDLE, tx_o=1, busy_o=0, grant_id_o=0, last_grant=NUM_REQ-1 (requester 0 first), counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame: tx_o=1 on the next cycle and the byte is dropped.
REQ-030 While rst_i is high, req_ready_o SHALL be all zero.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the FSM state enum and a default DIV_WIDTH constant.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last grant; output: one-hot grant and index).
REQ-033 Serializer and FSM SHALL reside in uart_tx_arb; no FIFO is included.

Verification
REQ-034 div_i=3, requester 0 sends 0x55 -> tx_o low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; busy_o high for 40 cycles.
REQ-035 All 4 requesters valid continuously (bytes 0xA0..0xA3) -> line order A0,A1,A2,A3,A0; each req_ready_o pulses once per grant; frame starts 41 cycles apart at div_i=3.
REQ-036 div_i=0, byte 0xFF -> 10-cycle frame: one low cycle, then nine high cycles.
REQ-037 div_i changed from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
REQ-038 rst_i asserted in DATA bit 3 -> tx_o=1 and busy_o=0 next cycle; after release, requester 0 has priority over requester 3.
REQ-039 Requester 2 drops valid while requester 1 transmits -> requester 2 is never granted; line stays idle after requester 1's frame.
